// File: rtl/bsdec_pkg.sv
// Shared types and width-derived constants for the unary bitstream decoder.
// Optional build macro: BSDEC_BIPOLAR_EN (signed result mapping).
package bsdec_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // Window length N = 2^bw enabled samples
  function automatic int win_len(input int bw);
    return 1 << bw;
  endfunction

  function automatic int half_len(input int bw);
    return 1 << (bw - 1);
  endfunction

  function automatic int umax_val(input int bw);
    return (1 << bw) - 1;
  endfunction

endpackage

// File: rtl/bsdecoder_if.sv
// Handshake and result bundle between a unary compute lane and the decoder.
// Optional build macro: BSDEC_BIPOLAR_EN (changes only the meaning of oData).
interface bsdecoder_if #(
  parameter int BITWIDTH = 8
);

  logic                iStart;
  logic                iEn;
  logic                iBit;
  logic                oBusy;
  logic                oValid;
  logic [BITWIDTH-1:0] oData;

  modport master (
    output iStart,
    output iEn,
    output iBit,
    input  oBusy,
    input  oValid,
    input  oData
  );

  modport slave (
    input  iStart,
    input  iEn,
    input  iBit,
    output oBusy,
    output oValid,
    output oData
  );

endinterface

// File: rtl/bsdec_accum.sv
// Window and ones counters for one accumulation window of 2^BITWIDTH enabled samples.
// Optional build macro: BSDEC_BIPOLAR_EN (not used here; counting is mapping-independent).
module bsdec_accum #(
  parameter int BITWIDTH = 8
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              clear,
  input  logic              enable,
  input  logic              sample_bit,
  output logic [BITWIDTH:0] ones_count,
  output logic              last_sample
);

  logic [BITWIDTH-1:0] win_q;
  logic [BITWIDTH-1:0] win_d;
  logic [BITWIDTH:0]   ones_q;
  logic [BITWIDTH:0]   ones_d;

  always_comb begin
    win_d  = win_q;
    ones_d = ones_q;
    if (clear) begin
      win_d  = '0;
      ones_d = '0;
    end else if (enable) begin
      win_d  = win_q + BITWIDTH'(1);
      ones_d = ones_q + (BITWIDTH+1)'(sample_bit);
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      win_q  <= '0;
      ones_q <= '0;
    end else begin
      win_q  <= win_d;
      ones_q <= ones_d;
    end
  end

  // Count includes the current sample so the top can register the final total on the last edge
  assign ones_count  = ones_d;
  assign last_sample = enable && !clear && (win_q == {BITWIDTH{1'b1}});

endmodule

// File: rtl/bsdecoder.sv
// Unary bitstream decoder: counts ones over 2^BITWIDTH enabled samples and emits the binary value.
// Optional build macro: BSDEC_BIPOLAR_EN selects a saturated two's-complement result.
module bsdecoder
  import bsdec_pkg::*;
#(
  parameter int BITWIDTH = 8
) (
  input logic        iClk,
  input logic        iRst,
  bsdecoder_if.slave bus
);

  localparam logic [BITWIDTH:0] WIN_LEN = (BITWIDTH+1)'(win_len(BITWIDTH));
`ifdef BSDEC_BIPOLAR_EN
  localparam logic [BITWIDTH-1:0] HALF = BITWIDTH'(half_len(BITWIDTH));
`else
  localparam logic [BITWIDTH-1:0] UMAX = BITWIDTH'(umax_val(BITWIDTH));
`endif

  state_e              state_q;
  state_e              state_d;
  logic                busy_q;
  logic                busy_d;
  logic                valid_q;
  logic                valid_d;
  logic [BITWIDTH-1:0] data_q;
  logic [BITWIDTH-1:0] data_d;
  logic [BITWIDTH-1:0] mapped;
  logic [BITWIDTH:0]   ones_count;
  logic                last_sample;
  logic                acc_clear;
  logic                acc_enable;

  // Gating by state keeps unknown iEn/iBit in IDLE away from the counters
  assign acc_clear  = (state_q == IDLE);
  assign acc_enable = (state_q == ACCUM) && bus.iEn;

  bsdec_accum #(
    .BITWIDTH (BITWIDTH)
  ) u_accum (
    .iClk        (iClk),
    .iRst        (iRst),
    .clear       (acc_clear),
    .enable      (acc_enable),
    .sample_bit  (bus.iBit),
    .ones_count  (ones_count),
    .last_sample (last_sample)
  );

  // Only a full window of ones reaches N, which is the single value needing saturation
  always_comb begin
`ifdef BSDEC_BIPOLAR_EN
    if (ones_count >= WIN_LEN) begin
      mapped = HALF - BITWIDTH'(1);
    end else begin
      mapped = ones_count[BITWIDTH-1:0] ^ HALF;
    end
`else
    if (ones_count >= WIN_LEN) begin
      mapped = UMAX;
    end else begin
      mapped = ones_count[BITWIDTH-1:0];
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    valid_d = 1'b0;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (bus.iStart) begin
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (last_sample) begin
          state_d = IDLE;
          valid_d = 1'b1;
          data_d  = mapped;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == ACCUM);
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign bus.oBusy  = busy_q;
  assign bus.oValid = valid_q;
  assign bus.oData  = data_q;

endmodule

// File: tb/tb_bsdecoder.sv
// Self-checking bench for bsdecoder with BITWIDTH=4 (N=16) against a counting reference model.
// Honours BSDEC_BIPOLAR_EN for the expected result mapping.
module tb_bsdecoder;

  localparam int BW = 4;
  localparam int N  = 16;

  logic iClk = 1'b0;
  logic iRst;

  int vectors     = 0;
  int miscompares = 0;

  int en_q[$];
  int bit_q[$];

  always #5 iClk = ~iClk;

  bsdecoder_if #(.BITWIDTH(BW)) bus ();

  bsdecoder #(
    .BITWIDTH (BW)
  ) dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus)
  );

  // Reference mapping straight from the arithmetic definition of the result
  function automatic logic [BW-1:0] expect_result(input int ones);
`ifdef BSDEC_BIPOLAR_EN
    int v;
    v = ones - N / 2;
    if (v > N / 2 - 1) v = N / 2 - 1;
    if (v < -(N / 2)) v = -(N / 2);
    return BW'(v);
`else
    return BW'((ones > N - 1) ? N - 1 : ones);
`endif
  endfunction

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic run_window(input string name, input bit random_start);
    int p;
    int seen;
    int ones;
    int edges;
    int idx;
    logic [BW-1:0] exp_data;
    p    = -1;
    seen = 0;
    ones = 0;
    for (int i = 0; i < en_q.size(); i++) begin
      if (en_q[i] != 0 && p < 0) begin
        seen++;
        ones += bit_q[i];
        if (seen == N) p = i;
      end
    end
    exp_data = expect_result(ones);

    bus.iStart = 1'b1;
    bus.iEn    = 1'bx;
    bus.iBit   = 1'bx;
    tick();
    edges      = 1;
    bus.iStart = 1'b0;
    vectors++;
    if (bus.oBusy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s busy_after_start: got %b expected 1", name, bus.oBusy);
    end

    idx = 0;
    while (bus.oValid !== 1'b1 && edges < 200) begin
      bus.iEn    = (idx < en_q.size()) ? (en_q[idx] != 0) : 1'b0;
      bus.iBit   = (idx < bit_q.size()) ? (bit_q[idx] != 0) : 1'b0;
      bus.iStart = random_start ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      edges++;
      idx++;
    end
    bus.iStart = 1'b0;
    bus.iEn    = 1'b0;
    bus.iBit   = 1'b0;

    vectors++;
    if (edges != p + 2) begin
      miscompares++;
      $display("[TB] FAIL %s latency: got %0d cycles expected %0d", name, edges, p + 2);
    end
    vectors++;
    if (bus.oData !== exp_data) begin
      miscompares++;
      $display("[TB] FAIL %s data: got %0d expected %0d", name, bus.oData, exp_data);
    end
    vectors++;
    if (bus.oBusy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s busy_at_valid: got %b expected 0", name, bus.oBusy);
    end
    tick();
    vectors++;
    if (bus.oValid !== 1'b0 || bus.oData !== exp_data) begin
      miscompares++;
      $display("[TB] FAIL %s pulse_hold: got valid=%b data=%0d expected valid=0 data=%0d",
               name, bus.oValid, bus.oData, exp_data);
    end
    en_q.delete();
    bit_q.delete();
  endtask

  task automatic test_reset();
    iRst       = 1'b1;
    bus.iStart = 1'b0;
    bus.iEn    = 1'bx;
    bus.iBit   = 1'bx;
    #22;
    vectors++;
    if (bus.oBusy !== 1'b0 || bus.oValid !== 1'b0 || bus.oData !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_values: got busy=%b valid=%b data=%0d expected 0 0 0",
               bus.oBusy, bus.oValid, bus.oData);
    end
    iRst = 1'b0;
    repeat (4) tick();
    vectors++;
    if (bus.oBusy !== 1'b0 || bus.oValid !== 1'b0 || bus.oData !== '0) begin
      miscompares++;
      $display("[TB] FAIL idle_x_inputs: got busy=%b valid=%b data=%0d expected 0 0 0",
               bus.oBusy, bus.oValid, bus.oData);
    end
  endtask

  task automatic test_half();
    int tmp;
    int j;
    for (int i = 0; i < N; i++) begin
      en_q.push_back(1);
      bit_q.push_back(i < N / 2 ? 1 : 0);
    end
    for (int i = N - 1; i > 0; i--) begin
      j        = $urandom_range(0, i);
      tmp      = bit_q[i];
      bit_q[i] = bit_q[j];
      bit_q[j] = tmp;
    end
    run_window("half_ones", 1'b0);
  endtask

  task automatic test_all_ones();
    for (int i = 0; i < N; i++) begin
      en_q.push_back(1);
      bit_q.push_back(1);
    end
    run_window("all_ones", 1'b0);
  endtask

  task automatic test_all_zeros();
    for (int i = 0; i < N; i++) begin
      en_q.push_back(1);
      bit_q.push_back(0);
    end
    run_window("all_zeros", 1'b0);
  endtask

  task automatic test_toggle();
    for (int i = 0; i < 2 * N + 4; i++) begin
      en_q.push_back((i % 2 == 0) ? 1 : 0);
      bit_q.push_back((i % 2 == 0) ? 0 : 1);
    end
    run_window("en_toggle", 1'b0);
  endtask

  // Sobol dimension-one sequence in Gray-code order, compared against a constant
  task automatic test_loopback();
    int x;
    int c;
    int n;
    x = 0;
    for (int i = 0; i < N; i++) begin
      en_q.push_back(1);
      bit_q.push_back((11 > x) ? 1 : 0);
      c = 0;
      n = i;
      while (n % 2 == 1) begin
        c++;
        n = n / 2;
      end
      x = x ^ ((N / 2) >> c);
    end
    run_window("sobol_loopback", 1'b0);
  endtask

  task automatic test_reset_mid();
    int valid_seen;
    int k;
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
    bus.iEn    = 1'b1;
    bus.iBit   = 1'b1;
    repeat (10) tick();
    #2;
    iRst = 1'b1;
    #1;
    vectors++;
    if (bus.oBusy !== 1'b0 || bus.oValid !== 1'b0 || bus.oData !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_outputs: got busy=%b valid=%b data=%0d expected 0 0 0",
               bus.oBusy, bus.oValid, bus.oData);
    end
    #3;
    iRst       = 1'b0;
    valid_seen = 0;
    repeat (20) begin
      tick();
      if (bus.oValid === 1'b1) valid_seen++;
    end
    vectors++;
    if (valid_seen != 0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_no_valid: got %0d pulses expected 0", valid_seen);
    end
    bus.iEn  = 1'b0;
    bus.iBit = 1'b0;
    for (int i = 0; i < N; i++) begin
      en_q.push_back(1);
      bit_q.push_back(0);
    end
    for (int i = 0; i < 5; i++) begin
      k = $urandom_range(0, N - 1);
      while (bit_q[k] != 0) k = (k + 1) % N;
      bit_q[k] = 1;
    end
    run_window("after_reset_five", 1'b0);
  endtask

  task automatic test_back_to_back();
    logic bits [0:50];
    logic exp_valid;
    int   ones;
    for (int k = 0; k <= 50; k++) bits[k] = 1'($urandom_range(0, 1));
    bus.iStart = 1'b1;
    bus.iEn    = 1'b1;
    for (int k = 0; k <= 50; k++) begin
      bus.iBit = bits[k];
      tick();
      exp_valid = (k % (N + 1) == N);
      vectors++;
      if (bus.oValid !== exp_valid) begin
        miscompares++;
        $display("[TB] FAIL b2b_valid edge %0d: got %b expected %b", k, bus.oValid, exp_valid);
      end
      if (exp_valid) begin
        ones = 0;
        for (int m = k - N + 1; m <= k; m++) ones += int'(bits[m]);
        vectors++;
        if (bus.oData !== expect_result(ones)) begin
          miscompares++;
          $display("[TB] FAIL b2b_data edge %0d: got %0d expected %0d",
                   k, bus.oData, expect_result(ones));
        end
      end
    end
    bus.iStart = 1'b0;
    bus.iEn    = 1'b0;
    bus.iBit   = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < 4 * N; i++) begin
        en_q.push_back(($urandom_range(0, 3) != 0) ? 1 : 0);
        bit_q.push_back($urandom_range(0, 1));
      end
      run_window("random_window", 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_half();
    test_all_ones();
    test_all_zeros();
    test_toggle();
    test_loopback();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bsdecoder.md
# bsdecoder

Unary bitstream decoder: the receiving end of the stochastic/unary datapath fed by the Sobol bitstream generators. It accepts one stochastic bit per enabled cycle and counts the ones over a fixed window of N = 2^BITWIDTH enabled samples. It then presents the count as a BITWIDTH-bit binary value with a one-cycle valid pulse, recovering the binary operand that a comparator-plus-sobolrng encoder turned into a bitstream. It sits at the output of unary compute lanes, ahead of any binary post-processing.

## Interface
- BITWIDTH, 8, binary width; window length N = 2^BITWIDTH enabled samples; supported 2-10
- iClk  in  1  clock, rising edge
- iRst  in  1  asynchronous reset, active-high
- iStart  in  1  request to open a new accumulation window; honoured only in IDLE
- iEn  in  1  sample qualifier; iBit counts only when iEn=1 in ACCUM
- iBit  in  1  stochastic bitstream input
- oBusy  out  1  high while in ACCUM
- oValid  out  1  one-cycle pulse: oData updated with a completed window result
- oData  out  BITWIDTH  decoded value, held until the next completed window

## Operation
- States: IDLE, ACCUM.
- IDLE:
  - iStart=1 → ACCUM.
  - Clear the ones counter and the window counter.
  - oData is unchanged.
- ACCUM:
  - On each cycle with iEn=1, the window counter increments and the ones counter adds iBit.
  - Cycles with iEn=0 are ignored entirely (no count, no window progress).
  - iStart is ignored.
- Window completion:
  - The Nth enabled sample, including its iBit, finishes the window.
  - On that edge: register oData from the final count, state → IDLE.
- Counting width: the ones counter is BITWIDTH+1 bits (range 0..N).
- Unipolar result (default): oData = min(ones, N-1). All-ones saturates to N-1 and never wraps to 0.
- Window counter: BITWIDTH bits; the Nth sample is detected by window count = N-1 with iEn=1.
- Back-to-back windows:
  - iStart=1 in the cycle oValid=1 (state IDLE) restarts immediately.
  - Minimum gap between windows is one IDLE cycle.
- Reset mid-window (iRst asserted during ACCUM):
  - The partial result is discarded and no oValid is produced.
  - All outputs go to reset values.
- iBit or iEn X/unknown while in IDLE must not affect state.

## Timing
- Reset values: state IDLE, oBusy=0, oValid=0, oData=0, counters 0.
- iStart sampled high at edge t → oBusy=1 from t+1.
- The first sample is counted at edge t+1 if iEn=1.
- With iEn held high, the last sample is at edge t+N. After that edge: oValid=1 and oData valid for one cycle, oBusy=0.
- oValid is always exactly one cycle wide. oData remains stable after oValid until the next oValid or reset.
- Latency from window start to result: N enabled samples + 1 cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- BSDEC_BIPOLAR_EN defined:
  - oData is two's-complement signed: ones − N/2, saturated to the range [−N/2, N/2−1].
  - Example: all-ones gives N/2−1; all-zeros gives −N/2; half ones gives 0.
- BSDEC_BIPOLAR_EN undefined: unipolar saturated count as above.
- The macro changes only the result mapping; timing and handshake are identical.

## Structure
- Shared package bsdec_pkg holds:
  - state enum (IDLE, ACCUM)
  - localparam-style constants derived from BITWIDTH: WIN_LEN = 2^BITWIDTH, HALF = 2^(BITWIDTH−1), UMAX = 2^BITWIDTH−1
- One sub-module, bsdec_accum. It holds the window counter and the ones counter, with inputs clear/enable/bit and outputs ones count plus a last-sample flag.
- The FSM and the result mapping/saturation live in the top.

## Test plan
All scenarios use BITWIDTH=4, N=16.
- Reset, then iStart pulse with iEn=1 and iBit=1 on 8 of 16 cycles → oValid exactly 17 cycles after iStart, oData=8 (bipolar: 0).
- All-ones window → oData=15, saturated, no wrap (bipolar: 7). All-zeros window → oData=0 (bipolar: −8 = 4'b1000).
- iEn toggling 1,0,1,0…, with iBit=1 only on iEn=0 cycles → window takes 32 cycles, oData=0.
- iStart held continuously → back-to-back results every 17 cycles; iStart pulses during ACCUM change nothing.
- iRst asserted after 10 samples of all-ones → outputs 0 immediately; no oValid. The next full window of 5 ones → oData=5.
- Encoder loopback: sobolrng (BITWIDTH 4) compared against a constant of 11 produces the bitstream → oData=11 exactly.
